// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command initiator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_cmd_master_pkg;

  // Transaction sequencer states: wait for command, run bus cycle, hold response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Response payload. The data field is sized for the widest supported bus
  // (64 bits); narrower instances use the low bits only.
  typedef struct packed {
    logic [63:0] dat;
    logic        we;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command stream, response stream and Wishbone classic bus of the initiator.
// Latency: n/a (wires only).
// Backpressure: s_cmd_ready / m_rsp_ready carry valid/ready flow control.
interface wb_cmd_master_if #(
  parameter int WB_ADR_WIDTH = 37,
  parameter int WB_DAT_WIDTH = 64,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);

  // Command stream
  logic                    s_cmd_we;
  logic [WB_ADR_WIDTH-1:0] s_cmd_adr;
  logic [WB_DAT_WIDTH-1:0] s_cmd_dat;
  logic [WB_SEL_WIDTH-1:0] s_cmd_sel;
  logic                    s_cmd_valid;
  logic                    s_cmd_ready;

  // Response stream
  logic [WB_DAT_WIDTH-1:0] m_rsp_dat;
  logic                    m_rsp_we;
  logic                    m_rsp_err;
  logic                    m_rsp_valid;
  logic                    m_rsp_ready;

  // Wishbone classic (cyc is implied by stb)
  logic [WB_ADR_WIDTH-1:0] m_wb_adr_o;
  logic [WB_DAT_WIDTH-1:0] m_wb_dat_o;
  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i;
  logic [WB_SEL_WIDTH-1:0] m_wb_sel_o;
  logic                    m_wb_we_o;
  logic                    m_wb_stb_o;
  logic                    m_wb_ack_i;

  // Initiator view
  modport master (
    input  s_cmd_we, s_cmd_adr, s_cmd_dat, s_cmd_sel, s_cmd_valid,
    output s_cmd_ready,
    output m_rsp_dat, m_rsp_we, m_rsp_err, m_rsp_valid,
    input  m_rsp_ready,
    output m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  // Environment view: command source, response sink and Wishbone slave
  modport slave (
    output s_cmd_we, s_cmd_adr, s_cmd_dat, s_cmd_sel, s_cmd_valid,
    input  s_cmd_ready,
    input  m_rsp_dat, m_rsp_we, m_rsp_err, m_rsp_valid,
    output m_rsp_ready,
    input  m_wb_adr_o, m_wb_dat_o, m_wb_sel_o, m_wb_we_o, m_wb_stb_o,
    output m_wb_dat_i, m_wb_ack_i
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Counts strobe cycles of one bus transfer and flags the abort point.
// Latency: terminal is combinational from the registered count.
// Backpressure: none; saturates at TIMEOUT_CYCLES-1 and never wraps.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt_q;

  assign terminal = (cnt_q == LAST);

  // Clear wins over enable; counting stops at the terminal value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !terminal) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one bus cycle per command, one response per command.
// Latency: accept->stb 1 cycle, ack->rsp_valid 1 cycle; 3 cycles/command at best.
// Backpressure: s_cmd_ready only in IDLE; response held until m_rsp_ready.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int WB_ADR_WIDTH   = 37,
  parameter int WB_DAT_WIDTH   = 64,
  parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES)
) (
  input  logic            clk,
  input  logic            reset_n,
  wb_cmd_master_if.master bus,
  output logic            busy,
  output logic            stray_ack
);

  state_t                  state_q, state_d;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
  logic [WB_SEL_WIDTH-1:0] sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    stb_q, stb_d;
  rsp_t                    rsp_q, rsp_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic                    busy_q;
  logic                    stray_q;
  logic                    rdy_en_q;
  logic                    accept;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    cnt_term;

  // Ready stays low while in reset and rises on the first clock after release.
  assign bus.s_cmd_ready = rdy_en_q && (state_q == IDLE);
  assign accept          = bus.s_cmd_valid && bus.s_cmd_ready;
  assign cnt_en          = (state_q == BUS);

  assign bus.m_wb_adr_o  = adr_q;
  assign bus.m_wb_dat_o  = dat_q;
  assign bus.m_wb_sel_o  = sel_q;
  assign bus.m_wb_we_o   = we_q;
  assign bus.m_wb_stb_o  = stb_q;
  assign bus.m_rsp_dat   = rsp_q.dat[WB_DAT_WIDTH-1:0];
  assign bus.m_rsp_we    = rsp_q.we;
  assign bus.m_rsp_err   = rsp_q.err;
  assign bus.m_rsp_valid = rsp_vld_q;
  assign busy            = busy_q;
  assign stray_ack       = stray_q;

  wb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_WIDTH      (TO_WIDTH)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (cnt_term)
  );

  // Next state and next register values; everything holds unless a case moves it.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    stb_d     = stb_q;
    rsp_d     = rsp_q;
    rsp_vld_d = rsp_vld_q;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d   = bus.s_cmd_adr;
          dat_d   = bus.s_cmd_dat;
          sel_d   = bus.s_cmd_sel;
          we_d    = bus.s_cmd_we;
          stb_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (bus.m_wb_ack_i) begin
          stb_d     = 1'b0;
          rsp_d.dat = we_q ? '0 : 64'(bus.m_wb_dat_i);
          rsp_d.we  = we_q;
          rsp_d.err = 1'b0;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end else if (cnt_term) begin
          stb_d     = 1'b0;
          rsp_d.dat = '0;
          rsp_d.we  = we_q;
          rsp_d.err = 1'b1;
          rsp_vld_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.m_rsp_ready) begin
          rsp_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        stb_d     = 1'b0;
        rsp_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; asynchronous reset drops stb and rsp_valid at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      stb_q     <= 1'b0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      stray_q   <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      stb_q     <= stb_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
      busy_q    <= (state_d != IDLE);
      stray_q   <= bus.m_wb_ack_i && (state_q != BUS);
      rdy_en_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for the Wishbone command initiator.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: response ready is driven per scenario.
module tb_wb_cmd_master;

  localparam int AW = 37;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic stray_ack;
  int   n_cmp = 0;
  int   n_bad = 0;

  wb_cmd_master_if #(.WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW), .WB_SEL_WIDTH(SW)) bus ();

  wb_cmd_master #(
    .WB_ADR_WIDTH   (AW),
    .WB_DAT_WIDTH   (DW),
    .WB_SEL_WIDTH   (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .stray_ack (stray_ack)
  );

  always #5 clk = ~clk;

  // Present one command for one clock edge; caller must be in IDLE at a falling edge.
  task automatic issue(input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel);
    bus.s_cmd_we    = we;
    bus.s_cmd_adr   = adr;
    bus.s_cmd_dat   = dat;
    bus.s_cmd_sel   = sel;
    bus.s_cmd_valid = 1'b1;
    @(negedge clk);
    bus.s_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.s_cmd_we = 0; bus.s_cmd_adr = '0; bus.s_cmd_dat = '0; bus.s_cmd_sel = '0;
    bus.s_cmd_valid = 0; bus.m_rsp_ready = 1; bus.m_wb_dat_i = '0; bus.m_wb_ack_i = 0;
    reset_n = 0;
    @(negedge clk);
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL reset_stb got=%b exp=0", bus.m_wb_stb_o); end
    n_cmp++; if (bus.m_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.m_rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (bus.s_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.s_cmd_ready); end
    n_cmp++; if (bus.m_wb_adr_o !== 37'h0) begin n_bad++; $display("FAIL reset_adr got=%h exp=0", bus.m_wb_adr_o); end
    n_cmp++; if (bus.m_rsp_dat !== 64'h0 || bus.m_rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp got=%h/%b exp=0/0", bus.m_rsp_dat, bus.m_rsp_err); end
    n_cmp++; if (stray_ack !== 1'b0) begin n_bad++; $display("FAIL reset_stray got=%b exp=0", stray_ack); end
    reset_n = 1;
    @(negedge clk);
    n_cmp++; if (bus.s_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got=%b exp=1", bus.s_cmd_ready); end
  endtask

  task automatic test_write();
    issue(1'b1, 37'h10, 64'h1122_3344_5566_7788, 8'hFF);
    n_cmp++; if (bus.m_wb_stb_o !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL wr_stb got stb=%b busy=%b exp=1/1", bus.m_wb_stb_o, busy); end
    n_cmp++; if (bus.m_wb_adr_o !== 37'h10 || bus.m_wb_we_o !== 1'b1 || bus.m_wb_sel_o !== 8'hFF) begin n_bad++; $display("FAIL wr_ctl got adr=%h we=%b sel=%h exp=10/1/ff", bus.m_wb_adr_o, bus.m_wb_we_o, bus.m_wb_sel_o); end
    n_cmp++; if (bus.m_wb_dat_o !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL wr_dat got=%h exp=1122334455667788", bus.m_wb_dat_o); end
    n_cmp++; if (bus.s_cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wr_ready_in_bus got=%b exp=0", bus.s_cmd_ready); end
    bus.m_wb_dat_i = 64'hFFFF_0000_FFFF_0000;
    bus.m_wb_ack_i = 1;
    @(negedge clk);
    bus.m_wb_ack_i = 0;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL wr_stb_one_cycle got=%b exp=0", bus.m_wb_stb_o); end
    n_cmp++; if (bus.m_rsp_valid !== 1'b1 || bus.m_rsp_we !== 1'b1 || bus.m_rsp_err !== 1'b0) begin n_bad++; $display("FAIL wr_rsp got v=%b we=%b err=%b exp=1/1/0", bus.m_rsp_valid, bus.m_rsp_we, bus.m_rsp_err); end
    n_cmp++; if (bus.m_rsp_dat !== 64'h0) begin n_bad++; $display("FAIL wr_rsp_dat got=%h exp=0", bus.m_rsp_dat); end
    @(negedge clk);
    n_cmp++; if (bus.m_rsp_valid !== 1'b0 || bus.s_cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL wr_back_idle got v=%b rdy=%b busy=%b exp=0/1/0", bus.m_rsp_valid, bus.s_cmd_ready, busy); end
  endtask

  task automatic test_read_wait();
    bus.m_wb_dat_i = 64'hDEAD_BEEF_0000_0001;
    issue(1'b0, 37'h18, 64'h9999_9999_9999_9999, 8'h0F);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (bus.m_wb_stb_o !== 1'b1 || bus.m_wb_adr_o !== 37'h18 || bus.m_wb_we_o !== 1'b0 || bus.m_wb_sel_o !== 8'h0F) begin
        n_bad++; $display("FAIL rd_stable cyc=%0d got stb=%b adr=%h we=%b sel=%h exp=1/18/0/0f", i, bus.m_wb_stb_o, bus.m_wb_adr_o, bus.m_wb_we_o, bus.m_wb_sel_o);
      end
      if (i == 5) bus.m_wb_ack_i = 1;
      @(negedge clk);
    end
    bus.m_wb_ack_i = 0;
    bus.m_wb_dat_i = '0;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0 || bus.m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_done got stb=%b v=%b exp=0/1", bus.m_wb_stb_o, bus.m_rsp_valid); end
    n_cmp++; if (bus.m_rsp_dat !== 64'hDEAD_BEEF_0000_0001 || bus.m_rsp_err !== 1'b0 || bus.m_rsp_we !== 1'b0) begin n_bad++; $display("FAIL rd_rsp got dat=%h err=%b we=%b exp=deadbeef00000001/0/0", bus.m_rsp_dat, bus.m_rsp_err, bus.m_rsp_we); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cnt;
    bus.m_wb_dat_i = 64'h7777_7777_7777_7777;
    issue(1'b1, 37'h20, 64'hA5A5, 8'h03);
    cnt = 0;
    while (bus.m_wb_stb_o === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++; if (cnt !== 16) begin n_bad++; $display("FAIL to_stb_cycles got=%0d exp=16", cnt); end
    n_cmp++; if (bus.m_rsp_valid !== 1'b1 || bus.m_rsp_err !== 1'b1 || bus.m_rsp_we !== 1'b1) begin n_bad++; $display("FAIL to_rsp got v=%b err=%b we=%b exp=1/1/1", bus.m_rsp_valid, bus.m_rsp_err, bus.m_rsp_we); end
    n_cmp++; if (bus.m_rsp_dat !== 64'h0) begin n_bad++; $display("FAIL to_rsp_dat got=%h exp=0", bus.m_rsp_dat); end
    @(negedge clk);
    bus.m_wb_dat_i = 64'h0123_4567_89AB_CDEF;
    issue(1'b0, 37'h28, 64'h0, 8'hFF);
    bus.m_wb_ack_i = 1;
    @(negedge clk);
    bus.m_wb_ack_i = 0;
    n_cmp++; if (bus.m_rsp_valid !== 1'b1 || bus.m_rsp_err !== 1'b0 || bus.m_rsp_dat !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL to_next_cmd got v=%b err=%b dat=%h exp=1/0/0123456789abcdef", bus.m_rsp_valid, bus.m_rsp_err, bus.m_rsp_dat); end
    @(negedge clk);
  endtask

  task automatic test_ack_at_terminal();
    bus.m_wb_dat_i = 64'hCAFE_F00D_1234_5678;
    issue(1'b0, 37'h30, 64'h0, 8'hF0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_cmp++; if (bus.m_wb_stb_o !== 1'b1) begin n_bad++; $display("FAIL term_stb_still_high got=%b exp=1", bus.m_wb_stb_o); end
        bus.m_wb_ack_i = 1;
      end
      @(negedge clk);
    end
    bus.m_wb_ack_i = 0;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0 || bus.m_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL term_done got stb=%b v=%b exp=0/1", bus.m_wb_stb_o, bus.m_rsp_valid); end
    n_cmp++; if (bus.m_rsp_err !== 1'b0 || bus.m_rsp_dat !== 64'hCAFE_F00D_1234_5678) begin n_bad++; $display("FAIL term_ack_wins got err=%b dat=%h exp=0/cafef00d12345678", bus.m_rsp_err, bus.m_rsp_dat); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bus.m_rsp_ready = 0;
    bus.m_wb_dat_i = 64'h5555_AAAA_0F0F_F0F0;
    issue(1'b0, 37'h40, 64'h0, 8'hFF);
    bus.m_wb_ack_i = 1;
    @(negedge clk);
    bus.m_wb_ack_i = 0;
    bus.m_wb_dat_i = '0;
    // A second command waits at the input the whole time.
    bus.s_cmd_we = 1; bus.s_cmd_adr = 37'h48; bus.s_cmd_dat = 64'h4848; bus.s_cmd_sel = 8'h01;
    bus.s_cmd_valid = 1;
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (bus.m_rsp_valid !== 1'b1 || bus.m_rsp_dat !== 64'h5555_AAAA_0F0F_F0F0 || bus.m_rsp_err !== 1'b0 ||
          bus.s_cmd_ready !== 1'b0 || bus.m_wb_stb_o !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold cyc=%0d got v=%b dat=%h err=%b rdy=%b stb=%b exp=1/5555aaaa0f0ff0f0/0/0/0", i, bus.m_rsp_valid, bus.m_rsp_dat, bus.m_rsp_err, bus.s_cmd_ready, bus.m_wb_stb_o);
      end
      @(negedge clk);
    end
    bus.m_rsp_ready = 1;
    @(negedge clk);
    n_cmp++; if (bus.m_rsp_valid !== 1'b0 || bus.s_cmd_ready !== 1'b1 || bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL bp_release got v=%b rdy=%b stb=%b exp=0/1/0", bus.m_rsp_valid, bus.s_cmd_ready, bus.m_wb_stb_o); end
    @(negedge clk);
    bus.s_cmd_valid = 0;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b1 || bus.m_wb_adr_o !== 37'h48 || bus.m_wb_we_o !== 1'b1) begin n_bad++; $display("FAIL bp_next_cmd got stb=%b adr=%h we=%b exp=1/48/1", bus.m_wb_stb_o, bus.m_wb_adr_o, bus.m_wb_we_o); end
    bus.m_wb_ack_i = 1;
    @(negedge clk);
    bus.m_wb_ack_i = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_stb;
    int n_rsp;
    n_stb = 0; n_rsp = 0;
    bus.m_rsp_ready = 1;
    bus.m_wb_dat_i = 64'h0BAD_C0DE_0000_0050;
    bus.s_cmd_we = 0; bus.s_cmd_adr = 37'h50; bus.s_cmd_dat = '0; bus.s_cmd_sel = 8'hFF;
    bus.s_cmd_valid = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.m_wb_stb_o === 1'b1) n_stb++;
      if (bus.m_rsp_valid === 1'b1) n_rsp++;
      bus.m_wb_ack_i = bus.m_wb_stb_o;
    end
    bus.s_cmd_valid = 0;
    bus.m_wb_ack_i = 0;
    n_cmp++; if (n_stb !== 4) begin n_bad++; $display("FAIL b2b_stb_count got=%0d exp=4", n_stb); end
    n_cmp++; if (n_rsp !== 4) begin n_bad++; $display("FAIL b2b_rsp_count got=%0d exp=4", n_rsp); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || bus.s_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle got busy=%b rdy=%b exp=0/1", busy, bus.s_cmd_ready); end
  endtask

  task automatic test_reset_mid_and_stray();
    issue(1'b1, 37'h60, 64'h6060, 8'hFF);
    @(negedge clk);
    reset_n = 0;
    #1;
    n_cmp++; if (bus.m_wb_stb_o !== 1'b0 || bus.m_rsp_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst got stb=%b v=%b busy=%b exp=0/0/0", bus.m_wb_stb_o, bus.m_rsp_valid, busy); end
    n_cmp++; if (bus.m_wb_adr_o !== 37'h0) begin n_bad++; $display("FAIL midrst_adr got=%h exp=0", bus.m_wb_adr_o); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    n_cmp++; if (bus.s_cmd_ready !== 1'b1 || bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL midrst_recover got rdy=%b stb=%b exp=1/0", bus.s_cmd_ready, bus.m_wb_stb_o); end
    bus.m_wb_ack_i = 1;
    @(negedge clk);
    bus.m_wb_ack_i = 0;
    n_cmp++; if (stray_ack !== 1'b1) begin n_bad++; $display("FAIL stray_pulse got=%b exp=1", stray_ack); end
    n_cmp++; if (busy !== 1'b0 || bus.m_rsp_valid !== 1'b0 || bus.m_wb_stb_o !== 1'b0) begin n_bad++; $display("FAIL stray_no_change got busy=%b v=%b stb=%b exp=0/0/0", busy, bus.m_rsp_valid, bus.m_wb_stb_o); end
    @(negedge clk);
    n_cmp++; if (stray_ack !== 1'b0 || bus.s_cmd_ready !== 1'b1) begin n_bad++; $display("FAIL stray_one_cycle got stray=%b rdy=%b exp=0/1", stray_ack, bus.s_cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_ack_at_terminal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_and_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
